// File: rtl/drive_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drive_pkg
// Purpose  : Shared types and constants for the drive command arbiter:
//            mode encoding, command class codes, direction codes and the
//            direction code to one-hot helper.
// Revision : 1.0  initial release
// ============================================================================
package drive_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b01,
    AUTO   = 2'b10,
    FAULT  = 2'b11
  } mode_e;

  // Command class field cmd[7:6]
  localparam logic [1:0] CLS_MODE  = 2'b00;
  localparam logic [1:0] CLS_MOVE  = 2'b01;
  localparam logic [1:0] CLS_SPEED = 2'b10;
  localparam logic [1:0] CLS_RSVD  = 2'b11;

  // Direction codes, bit position in the one-hot vector equals the code
  localparam logic [3:0] DIR_W    = 4'd0;
  localparam logic [3:0] DIR_S    = 4'd1;
  localparam logic [3:0] DIR_A    = 4'd2;
  localparam logic [3:0] DIR_D    = 4'd3;
  localparam logic [3:0] DIR_WA   = 4'd4;
  localparam logic [3:0] DIR_WD   = 4'd5;
  localparam logic [3:0] DIR_AS   = 4'd6;
  localparam logic [3:0] DIR_DS   = 4'd7;
  localparam logic [3:0] DIR_STOP = 4'd8;

  localparam logic [8:0] DIR_STOP_OH = 9'h100;

  // Codes outside 0..8 map to stop so an out-of-range code never moves the car
  function automatic logic [8:0] dir_code_to_onehot(input logic [3:0] code);
    if (code <= DIR_STOP) return 9'd1 << code;
    else                  return DIR_STOP_OH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drive_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : drive_cmd_arbiter_if
// Purpose  : Bundle of the command/planner inputs and the merged drive
//            outputs of the arbiter. master = link side, slave = arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface drive_cmd_arbiter_if #(
  parameter int CMD_W   = 8,
  parameter int SPEED_W = 6
);
  logic [CMD_W-1:0]   cmd;
  logic               cmd_valid;
  logic [3:0]         auto_dir;
  logic               auto_valid;
  logic [8:0]         dir;
  logic [SPEED_W-1:0] speed;
  logic [1:0]         mode;
  logic               manual_on;
  logic               auto_on;
  logic               fault;
  logic               cmd_err;

  modport master (
    output cmd, cmd_valid, auto_dir, auto_valid,
    input  dir, speed, mode, manual_on, auto_on, fault, cmd_err
  );

  modport slave (
    input  cmd, cmd_valid, auto_dir, auto_valid,
    output dir, speed, mode, manual_on, auto_on, fault, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/drive_cmd_arbiter_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module   : speed_ramp
// Purpose  : Moves the output speed one LSB toward the target every RAMP_DIV
//            cycles; forces zero while the car is commanded to stop.
// Revision : 1.0  initial release
// ============================================================================
module speed_ramp #(
  parameter int SPEED_W  = 6,
  parameter int RAMP_DIV = 250_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] target,
  input  logic               force_zero,
  output logic [SPEED_W-1:0] speed
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Free-running step divider; target changes do not restart it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // One-LSB step toward target on each tick, no overshoot
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         speed <= '0;
    else if (force_zero)             speed <= '0;
    else if (tick && speed < target) speed <= speed + 1'b1;
    else if (tick && speed > target) speed <= speed - 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/drive_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : drive_cmd_arbiter
// Purpose  : Decodes the link command stream, runs the idle/manual/auto/fault
//            mode machine and the link watchdog, and merges link and planner
//            directions into one registered drive interface.
// Revision : 1.0  initial release
// ============================================================================
module drive_cmd_arbiter
  import drive_pkg::*;
#(
  parameter int CMD_W          = 8,
  parameter int SPEED_W        = 6,
  parameter int TIMEOUT_CYCLES = 12_500_000,
  parameter int RAMP_DIV       = 250_000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  drive_cmd_arbiter_if.slave bus
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  mode_e              mode_q, mode_d;
  logic [8:0]         dir_q, dir_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic               manual_on_q, auto_on_q, fault_q;
  logic               kick;

  // Field decode of the command byte
  logic [1:0] cls;
  mode_e      mode_field;
  logic [3:0] move_code;
  logic       move_ok, is_mode, is_move, is_speed;

  assign cls        = bus.cmd[7:6];
  assign mode_field = mode_e'(bus.cmd[1:0]);
  assign move_code  = bus.cmd[3:0];
  assign move_ok    = (move_code <= DIR_STOP);
  assign is_mode    = bus.cmd_valid && (cls == CLS_MODE);
  assign is_move    = bus.cmd_valid && (cls == CLS_MOVE);
  assign is_speed   = bus.cmd_valid && (cls == CLS_SPEED);

  // Mode/direction/target/watchdog next-state; a link MODE command takes
  // priority over a same-cycle planner strobe and over watchdog expiry
  always_comb begin
    mode_d   = mode_q;
    dir_d    = dir_q;
    target_d = target_q;
    wd_d     = '0;
    kick     = 1'b0;
    // Malformed bytes are flagged in every mode, including FAULT
    err_d    = bus.cmd_valid && ((cls == CLS_RSVD) || ((cls == CLS_MOVE) && !move_ok));

    if (is_speed && mode_q != FAULT) target_d = bus.cmd[SPEED_W-1:0];

    unique case (mode_q)
      IDLE: begin
        if (is_mode && mode_field != IDLE) mode_d = mode_field;
      end
      MANUAL: begin
        if (is_mode)                 mode_d = mode_field;
        else if (is_move && move_ok) dir_d  = dir_code_to_onehot(move_code);
      end
      AUTO: begin
        if (is_mode)             mode_d = mode_field;
        else if (bus.auto_valid) dir_d  = dir_code_to_onehot(bus.auto_dir);
      end
      FAULT: begin
        if (is_mode && mode_field == IDLE) mode_d = IDLE;
      end
      default: ;
    endcase

    if (mode_q == MANUAL || mode_q == AUTO) begin
      kick = bus.cmd_valid || (mode_q == AUTO && bus.auto_valid);
      if (kick)                wd_d = '0;
      else if (wd_q == WD_LAST) begin
        mode_d = FAULT;
        wd_d   = '0;
      end
      else                     wd_d = wd_q + 1'b1;
    end

    if (mode_d != mode_q) begin
      dir_d = DIR_STOP_OH;
      wd_d  = '0;
      if (mode_d == FAULT) target_d = '0;
    end

    if (mode_d == IDLE || mode_d == FAULT) dir_d = DIR_STOP_OH;
  end

  // State register; all outputs come straight from flops
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mode_q      <= IDLE;
      dir_q       <= DIR_STOP_OH;
      target_q    <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      manual_on_q <= 1'b0;
      auto_on_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      target_q    <= target_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      manual_on_q <= (mode_d == MANUAL);
      auto_on_q   <= (mode_d == AUTO);
      fault_q     <= (mode_d == FAULT);
    end
  end

  speed_ramp #(
    .SPEED_W  (SPEED_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_speed_ramp (
    .clk        (CLOCK_50),
    .rst        (reset),
    .target     (target_q),
    .force_zero (dir_q == DIR_STOP_OH),
    .speed      (bus.speed)
  );

  assign bus.dir       = dir_q;
  assign bus.mode      = mode_q;
  assign bus.manual_on = manual_on_q;
  assign bus.auto_on   = auto_on_q;
  assign bus.fault     = fault_q;
  assign bus.cmd_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_drive_cmd_arbiter
// Purpose  : Scoreboard bench for drive_cmd_arbiter: directed scenarios plus
//            random traffic, expected outputs from a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_drive_cmd_arbiter;

  localparam int CMD_W   = 8;
  localparam int SPEED_W = 6;
  localparam int TMO     = 16;
  localparam int RDIV    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  drive_cmd_arbiter_if #(.CMD_W(CMD_W), .SPEED_W(SPEED_W)) bus ();

  drive_cmd_arbiter #(
    .CMD_W          (CMD_W),
    .SPEED_W        (SPEED_W),
    .TIMEOUT_CYCLES (TMO),
    .RAMP_DIV       (RDIV)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Cycle index used to line up expectations with DUT edges
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [8:0] dir;
    logic [5:0] speed;
    logic [1:0] mode;
    logic       man, aut, flt, err;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: mode 0..3, direction as code 0..8 (8 = stop)
  int m_mode, m_dir, m_target, m_speed, m_wd, m_div;
  bit m_err;

  task automatic model_reset();
    m_mode = 0; m_dir = 8; m_target = 0; m_speed = 0;
    m_wd = 0; m_div = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r, input logic [7:0] c, input bit cv,
                            input logic [3:0] ad, input bit av);
    int cls, fld, code, nmode, ndir, ntgt, nspd;
    bit tick;
    if (r) model_reset();
    else begin
      cls  = int'(c[7:6]);
      fld  = int'(c[1:0]);
      code = int'(c[3:0]);
      tick = (m_div == RDIV - 1);
      m_div = tick ? 0 : m_div + 1;
      if (m_dir == 8)                       nspd = 0;
      else if (tick && m_speed < m_target)  nspd = m_speed + 1;
      else if (tick && m_speed > m_target)  nspd = m_speed - 1;
      else                                  nspd = m_speed;
      nmode = m_mode; ndir = m_dir; ntgt = m_target;
      if (cv && cls == 2 && m_mode != 3) ntgt = int'(c[5:0]);
      case (m_mode)
        0: if (cv && cls == 0 && fld != 0) nmode = fld;
        1: if (cv && cls == 0) nmode = fld;
           else if (cv && cls == 1 && code <= 8) ndir = code;
        2: if (cv && cls == 0) nmode = fld;
           else if (av) ndir = (int'(ad) <= 8) ? int'(ad) : 8;
        default: if (cv && cls == 0 && fld == 0) nmode = 0;
      endcase
      if (m_mode == 1 || m_mode == 2) begin
        if (cv || (m_mode == 2 && av)) m_wd = 0;
        else if (m_wd == TMO - 1) begin nmode = 3; m_wd = 0; end
        else m_wd = m_wd + 1;
      end else m_wd = 0;
      if (nmode != m_mode) begin
        ndir = 8; m_wd = 0;
        if (nmode == 3) ntgt = 0;
      end
      if (nmode == 0 || nmode == 3) ndir = 8;
      m_err    = cv && (cls == 3 || (cls == 1 && code > 8));
      m_mode   = nmode; m_dir = ndir; m_target = ntgt; m_speed = nspd;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.due   = cyc + 1;
    e.dir   = 9'd1 << m_dir;
    e.speed = 6'(m_speed);
    e.mode  = 2'(m_mode);
    e.man   = (m_mode == 1);
    e.aut   = (m_mode == 2);
    e.flt   = (m_mode == 3);
    e.err   = m_err;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it
  // against the expectation due for that edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("dir",       32'(bus.dir),       32'(e.dir));
      chk("speed",     32'(bus.speed),     32'(e.speed));
      chk("mode",      32'(bus.mode),      32'(e.mode));
      chk("manual_on", 32'(bus.manual_on), 32'(e.man));
      chk("auto_on",   32'(bus.auto_on),   32'(e.aut));
      chk("fault",     32'(bus.fault),     32'(e.flt));
      chk("cmd_err",   32'(bus.cmd_err),   32'(e.err));
    end
  end

  task automatic step(input bit r, input logic [7:0] c, input bit cv,
                      input logic [3:0] ad, input bit av);
    @(posedge clk);
    #1;
    rst            = r;
    bus.cmd        = c;
    bus.cmd_valid  = cv;
    bus.auto_dir   = ad;
    bus.auto_valid = av;
    model_step(r, c, cv, ad, av);
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b0, c, 1'b1, 4'd0, 1'b0);
  endtask

  // Reset between edges; outputs must drop before the next clock edge
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.auto_valid = 1'b0;
    model_reset();
    sb.delete();
    #1;
    chk("async dir",       32'(bus.dir),       32'h100);
    chk("async speed",     32'(bus.speed),     32'h0);
    chk("async mode",      32'(bus.mode),      32'h0);
    chk("async manual_on", 32'(bus.manual_on), 32'h0);
    chk("async auto_on",   32'(bus.auto_on),   32'h0);
    chk("async fault",     32'(bus.fault),     32'h0);
    chk("async cmd_err",   32'(bus.cmd_err),   32'h0);
    step(1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int pct;
    bit cv, av;
    logic [7:0] c;
    bus.cmd = '0; bus.cmd_valid = 1'b0; bus.auto_dir = '0; bus.auto_valid = 1'b0;
    model_reset();
    step(1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 4'd0, 1'b0);
    idle(2);

    // Manual entry and first move
    send(8'h01); send(8'h40); idle(2);

    // Ramp to 20, keep link alive, then stop
    send(8'h94); send(8'h40);
    for (int i = 0; i < 12; i++) begin idle(7); send(8'h40); end
    send(8'h48); idle(3);

    // Watchdog expiry, ignored move in fault, exit to idle
    send(8'h40); idle(TMO + 4);
    send(8'h41); idle(1); send(8'h00); idle(2);

    // Auto: planner wins over link MOVE, out-of-range planner code stops
    send(8'h02); idle(1);
    step(1'b0, 8'h41, 1'b1, 4'd4, 1'b1); idle(1);
    step(1'b0, 8'h00, 1'b0, 4'd4, 1'b1);
    send(8'h41); idle(1);
    step(1'b0, 8'h00, 1'b0, 4'd12, 1'b1); idle(1);
    step(1'b0, 8'h01, 1'b1, 4'd3, 1'b1); idle(1);

    // Malformed commands
    send(8'hC0); send(8'h4C); idle(2);

    // Auto ramp then asynchronous reset mid-ramp
    send(8'h02); send(8'h9E);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 4'd0, 1'b1); idle(5);
    end
    async_reset();
    idle(2);

    // Random traffic with sparse and busy stretches
    for (int blk = 0; blk < 15; blk++) begin
      pct = (blk % 3 == 0) ? 2 : 30;
      for (int i = 0; i < 100; i++) begin
        cv = ($urandom_range(0, 99) < pct);
        av = ($urandom_range(0, 99) < 20);
        c  = 8'($urandom);
        if (c[7:6] == 2'b00 && c[1:0] == 2'b11 && $urandom_range(0, 3) != 0)
          c[1:0] = 2'($urandom_range(0, 2));
        step(1'b0, c, cv, 4'($urandom_range(0, 15)), av);
      end
    end
    idle(2);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
